mux_2to1: RTL and testbench

Two-input selector with a combinational output and a registered copy of that output. The combinational path returns `a` when `s`=0 and `b` when `s`=1. A clocked stage captures the selected value and counts how often the select line changes. The block is a leaf datapath primitive used wherever two sources share one sink.

---
 rtl/mux_2to1.sv | 56 +++++
 tb/tb_mux_2to1.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_2to1
//  Purpose  : Two-input selector with a combinational output, a registered
//             copy of that output and a saturating select-change counter.
//  Revision : 1.0  initial release
// ============================================================================
module mux_2to1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             s,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] sel_chg
);

  // Previous sampled value of the select line, used to detect changes.
  logic s_q;

  // Counter is full when every bit is set; it must hold there, never wrap.
  logic cnt_full;
  assign cnt_full = &sel_chg;

  // Select the data source; an unknown select propagates as unknown data
  // so that neither input is silently favoured in simulation.
  always_comb begin
    y = '0;
    case (s)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end

  // Capture the selected data and track select-line changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      s_q     <= 1'b0;
      sel_chg <= '0;
    end else begin
      y_q <= y;
      s_q <= s;
      if ((s != s_q) && !cnt_full) begin
        sel_chg <= sel_chg + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_2to1
//  Purpose  : Self-checking bench for mux_2to1 (scoreboard on registered path)
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_2to1;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic clk_en = 1'b0;

  // Instance 1: WIDTH=1, CNT_W=8
  logic       a1 = 1'b0, b1 = 1'b0, s1 = 1'b0;
  logic       y1, yq1;
  logic [7:0] cnt1;
  // Instance 2: WIDTH=1, CNT_W=2 (saturation)
  logic       a2 = 1'b0, b2 = 1'b0, s2 = 1'b0;
  logic       y2, yq2;
  logic [1:0] cnt2;
  // Instance 3: WIDTH=8
  logic [7:0] a3 = 8'h00, b3 = 8'h00;
  logic       s3 = 1'b0;
  logic [7:0] y3, yq3, cnt3;

  mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .a(a1), .b(b1), .y(y1), .s(s1), .clk(clk), .rst(rst), .y_q(yq1), .sel_chg(cnt1));
  mux_2to1 #(.WIDTH(1), .CNT_W(2)) u_dut2 (
    .a(a2), .b(b2), .y(y2), .s(s2), .clk(clk), .rst(rst), .y_q(yq2), .sel_chg(cnt2));
  mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_dut3 (
    .a(a3), .b(b3), .y(y3), .s(s3), .clk(clk), .rst(rst), .y_q(yq3), .sel_chg(cnt3));

  // Gated 20 ns clock so the combinational table can run with no clock.
  always #10 if (clk_en) clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Reference state for instance 1's counter.
  logic       m_sq  = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return {31'd0, yq1};
      1:       return {24'd0, cnt1};
      default: return {24'd0, yq3};
    endcase
  endfunction

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive instance 1, check y at once, queue registered expectations.
  task automatic step1(input logic ia, input logic ib, input logic is, input string tag);
    logic ey;
    a1 = ia; b1 = ib; s1 = is;
    ey = is ? ib : ia;
    #1;
    check({tag, "_y"}, {31'd0, y1}, {31'd0, ey});
    if ((is != m_sq) && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
    m_sq = is;
    sb_q.push_back('{tag: {tag, "_yq"},  sel: 0, exp: {31'd0, ey}});
    sb_q.push_back('{tag: {tag, "_cnt"}, sel: 1, exp: {24'd0, m_cnt}});
    tick();
    drain();
  endtask

  // Truth table in spec order: (a,b,s) and the required y.
  logic [2:0] tt_in  [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
  logic       tt_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] sat_exp[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  // Main stimulus sequence.
  initial begin
    // Asynchronous reset with no clock running.
    #1 rst = 1'b1;
    a1 = 1'b1;
    #1;
    check("rst_yq", {31'd0, yq1}, 32'd0);
    check("rst_cnt", {24'd0, cnt1}, 32'd0);
    check("rst_cnt2", {30'd0, cnt2}, 32'd0);
    check("rst_y_valid", {31'd0, y1}, 32'd1);
    rst = 1'b0;
    a1 = 1'b0;

    // Combinational truth table, clock stopped, reset low.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, s1} = tt_in[i];
      #20;
      check($sformatf("tt%0d", i), {31'd0, y1}, {31'd0, tt_exp[i]});
    end
    {a1, b1, s1} = 3'b000;

    // Registered path and select counting.
    clk_en = 1'b1;
    step1(1'b1, 1'b0, 1'b0, "hold_a");
    step1(1'b1, 1'b0, 1'b1, "sel_b");
    step1(1'b1, 1'b0, 1'b0, "sel_a");
    step1(1'b0, 1'b1, 1'b1, "sel_b2");

    // Asynchronous reset between edges: state clears, y keeps tracking.
    #4 rst = 1'b1;
    #1;
    check("arst_yq", {31'd0, yq1}, 32'd0);
    check("arst_cnt", {24'd0, cnt1}, 32'd0);
    check("arst_y", {31'd0, y1}, 32'd1);
    m_sq  = 1'b0;
    m_cnt = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    // First edge after release compares against s_q = 0.
    step1(1'b1, 1'b1, 1'b1, "post_rst");
    step1(1'b0, 1'b1, 1'b1, "post_rst_hold");

    // Saturation on the 2-bit counter.
    for (int i = 0; i < 6; i++) begin
      s2 = ~s2;
      tick();
      check($sformatf("sat%0d", i), {30'd0, cnt2}, {30'd0, sat_exp[i]});
    end

    // WIDTH=8 data path.
    a3 = 8'hA5; b3 = 8'h3C; s3 = 1'b0;
    #1;
    check("w8_y_a", {24'd0, y3}, 32'h0000_00A5);
    sb_q.push_back('{tag: "w8_yq_a", sel: 2, exp: 32'h0000_00A5});
    tick();
    drain();
    s3 = 1'b1;
    #1;
    check("w8_y_b", {24'd0, y3}, 32'h0000_003C);
    check("w8_yq_lag", {24'd0, yq3}, 32'h0000_00A5);
    sb_q.push_back('{tag: "w8_yq_b", sel: 2, exp: 32'h0000_003C});
    tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
